// File: rtl/dot_prod_core.sv
// dot_prod_core: W·x matrix-vector engine, one column per cycle, one MAC per row; weight RAM loadable during reset.
// Define DOT_PROD_SATURATE_EN to saturate results instead of wrapping them.
module dot_prod_core #(
  parameter int NROW = 16,
  parameter int NCOL = 8,
  parameter int QN = 6,
  parameter int QM = 11,
  parameter int DSP48_PER_ROW = 4,
  parameter int BITWIDTH = QN + QM + 1,
  parameter int ADDR_BITWIDTH = $clog2(NCOL)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_BITWIDTH-1:0]   colAddressWrite,
  input  logic                       writeEn,
  input  logic [NROW*BITWIDTH-1:0]   weightMemInput,
  input  logic [BITWIDTH-1:0]        inputVec,
  output logic [ADDR_BITWIDTH-1:0]   colAddressRead,
  output logic                       dataReady,
  output logic [NROW*BITWIDTH-1:0]   outputVec
);
  localparam int PW = 2 * BITWIDTH;
  localparam int AW = PW + ADDR_BITWIDTH;
  localparam int CW = ADDR_BITWIDTH + 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
  logic [NROW*BITWIDTH-1:0] mem_q [NCOL];
  logic [NROW*BITWIDTH-1:0] rd_q, out_q, out_d;
  logic [BITWIDTH-1:0] x_q;
  logic signed [AW-1:0] acc_q [NROW];
  logic signed [AW-1:0] acc_d [NROW];
  logic rdy_q, rdy_d, acc_en, fin;

  if (DSP48_PER_ROW < 1) begin : g_bad_dsp
    $error("DSP48_PER_ROW must be at least 1");
  end

  function automatic logic signed [PW-1:0] mul(input logic signed [BITWIDTH-1:0] a, input logic signed [BITWIDTH-1:0] b);
    return a * b;
  endfunction

  function automatic logic [BITWIDTH-1:0] reduce(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = a >>> QM;
`ifdef DOT_PROD_SATURATE_EN
    if (&s[AW-1:BITWIDTH-1] || ~|s[AW-1:BITWIDTH-1]) return s[BITWIDTH-1:0];
    return s[AW-1] ? {1'b1, {(BITWIDTH-1){1'b0}}} : {1'b0, {(BITWIDTH-1){1'b1}}};
`else
    return BITWIDTH'(s);
`endif
  endfunction

  // RAM and x register are outside reset so weights survive and loading works while held in reset
  always_ff @(posedge clock) begin
    if (writeEn) mem_q[colAddressWrite] <= weightMemInput;
    rd_q <= mem_q[addr_q];
    x_q <= inputVec;
  end

  // cnt_q counts edges since reset release; columns land in rd_q/x_q while cnt_q is 1..NCOL
  always_comb begin
    acc_en = state_q == RUN && cnt_q <= CW'(NCOL);
    fin = state_q == RUN && cnt_q == CW'(NCOL + 1);
    state_d = state_q == IDLE ? RUN : (fin ? DONE : state_q);
    cnt_d = state_q == DONE ? cnt_q : cnt_q + 1'b1;
    addr_d = (state_q != DONE && addr_q != ADDR_BITWIDTH'(NCOL - 1)) ? addr_q + 1'b1 : addr_q;
    rdy_d = rdy_q | fin;
    out_d = out_q;
    for (int r = 0; r < NROW; r++) begin
      acc_d[r] = acc_en ? acc_q[r] + AW'(mul(rd_q[r*BITWIDTH +: BITWIDTH], x_q)) : acc_q[r];
      if (fin) out_d[r*BITWIDTH +: BITWIDTH] = reduce(acc_q[r]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      rdy_q <= 1'b0;
      out_q <= '0;
      acc_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      rdy_q <= rdy_d;
      out_q <= out_d;
      acc_q <= acc_d;
    end
  end

  assign colAddressRead = addr_q;
  assign dataReady = rdy_q;
  assign outputVec = out_q;
endmodule

// File: tb/tb_dot_prod_core.sv
// tb_dot_prod_core: directed vectors checked against an arithmetic model of y = (W·x) >>> QM.
module tb_dot_prod_core;
  localparam int NROW = 16, NCOL = 8, BW = 18, AB = 3;
  logic clock, reset, writeEn, dataReady;
  logic [AB-1:0] colAddressWrite, colAddressRead;
  logic [NROW*BW-1:0] weightMemInput, outputVec;
  logic [BW-1:0] inputVec;
  logic [BW-1:0] w [NROW][NCOL];
  logic [BW-1:0] xv [NCOL];
  int total = 0, passed = 0;

  dot_prod_core dut (
    .clock(clock), .reset(reset), .colAddressWrite(colAddressWrite), .writeEn(writeEn),
    .weightMemInput(weightMemInput), .inputVec(inputVec), .colAddressRead(colAddressRead),
    .dataReady(dataReady), .outputVec(outputVec)
  );

  assign inputVec = xv[colAddressRead];

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [BW-1:0] model(input int r);
    longint s = 0;
    for (int c = 0; c < NCOL; c++) s += longint'($signed(w[r][c])) * longint'($signed(xv[c]));
    s = s >>> 11;
`ifdef DOT_PROD_SATURATE_EN
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
`endif
    return s[BW-1:0];
  endfunction

  task automatic fill(input logic [BW-1:0] wv, input logic [BW-1:0] xval);
    for (int r = 0; r < NROW; r++) for (int c = 0; c < NCOL; c++) w[r][c] = wv;
    for (int c = 0; c < NCOL; c++) xv[c] = xval;
  endtask

  task automatic load();
    for (int c = 0; c < NCOL; c++) begin
      @(negedge clock);
      colAddressWrite = AB'(c);
      writeEn = 1;
      for (int r = 0; r < NROW; r++) weightMemInput[r*BW +: BW] = w[r][c];
    end
    @(negedge clock);
    writeEn = 0;
  endtask

  task automatic hold_reset();
    @(negedge clock);
    reset = 1;
    @(negedge clock);
  endtask

  task automatic run_and_check(input string nm);
    logic [BW-1:0] exp [NROW];
    for (int r = 0; r < NROW; r++) exp[r] = model(r);
    @(negedge clock);
    reset = 0;
    for (int k = 1; k <= NCOL + 5; k++) begin
      @(posedge clock);
      #1;
      chk({nm, "_addr"}, colAddressRead, (k < NCOL - 1) ? k : NCOL - 1);
      chk({nm, "_rdy"}, dataReady, k >= NCOL + 2);
      if (k >= NCOL + 2)
        for (int r = 0; r < NROW; r++) chk({nm, "_y"}, outputVec[r*BW +: BW], exp[r]);
    end
  endtask

  initial begin
    reset = 1;
    writeEn = 0;
    colAddressWrite = '0;
    weightMemInput = '0;
    fill('0, '0);
    repeat (2) @(negedge clock);
    chk("rst_rdy", dataReady, 0);
    chk("rst_out", outputVec, 0);
    chk("rst_addr", colAddressRead, 0);

    fill(18'h00800, 18'h00800);
    load();
    run_and_check("ones");
    chk("lit_ones", outputVec[BW-1:0], 18'h04000);
    hold_reset();

    fill(18'h3F800, 18'h01000);
    load();
    run_and_check("neg");
    chk("lit_neg", outputVec[5*BW +: BW], 18'h38000);
    hold_reset();

    fill(18'h00800, 18'h00800);
    load();
    run_and_check("big_pre");
    hold_reset();
    fill(18'h0F800, 18'h0F800);
    load();
    run_and_check("big");
`ifdef DOT_PROD_SATURATE_EN
    chk("lit_big", outputVec[15*BW +: BW], 18'h1FFFF);
`else
    chk("lit_big", outputVec[15*BW +: BW], 18'h04000);
`endif
    hold_reset();

    fill(18'h00001, 18'h00001);
    load();
    run_and_check("tiny");
    chk("lit_tiny", outputVec[2*BW +: BW], 18'h00000);
    hold_reset();

    fill('0, '0);
    for (int r = 0; r < NCOL; r++) w[r][r] = 18'h00800;
    for (int c = 0; c < NCOL; c++) xv[c] = BW'(c * 18'h00400);
    load();
    run_and_check("ident");
    chk("lit_ident3", outputVec[3*BW +: BW], 18'h00C00);
    chk("lit_ident9", outputVec[9*BW +: BW], 18'h00000);
    hold_reset();

    @(negedge clock);
    reset = 0;
    for (int k = 0; k < 100 && colAddressRead != 3; k++) @(negedge clock);
    chk("mid_addr3", colAddressRead, 3);
    reset = 1;
    @(posedge clock);
    #1;
    chk("mid_rdy", dataReady, 0);
    chk("mid_out", outputVec, 0);
    chk("mid_addr", colAddressRead, 0);
    run_and_check("rerun");
    chk("lit_rerun7", outputVec[7*BW +: BW], 18'h01C00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
